// File: rtl/neopixel_chain_if.sv
`timescale 1ns/1ps
// neopixel_chain_if: memory-mapped bus seen by the pixel-chain driver.
// Latency: plain wires; read data is combinational from the slave.
// Backpressure: none; every strobe is accepted in the cycle it is seen.
interface neopixel_chain_if;
    logic        bus_write_en;
    logic        bus_read_en;
    logic        np_en;
    logic [7:0]  bus_addr;
    logic [31:0] bus_write_data;
    logic [31:0] bus_read_data;

    modport master (
        output bus_write_en,
        output bus_read_en,
        output np_en,
        output bus_addr,
        output bus_write_data,
        input  bus_read_data
    );

    modport slave (
        input  bus_write_en,
        input  bus_read_en,
        input  np_en,
        input  bus_addr,
        input  bus_write_data,
        output bus_read_data
    );
endinterface

// File: rtl/neopixel_chain.sv
`timescale 1ns/1ps
// neopixel_chain: N-pixel GRB frame buffer serialised onto a one-wire WS2812 line.
// Latency: start sampled at edge N -> busy after N, first np_out high after N+1; reads combinational.
// Backpressure: none; bus always accepts, start/clear are dropped while a frame/latch runs.
// Optional feature: define NP_AUTO_REFRESH_EN for CTRL bit2 auto-refresh (LATCH loops back to SEND).
module neopixel_chain #(
    parameter int NUM_PIXELS = 8,
    parameter int T0H        = 40,
    parameter int T1H        = 80,
    parameter int T_BIT      = 125,
    parameter int T_LATCH    = 5000,
    parameter int CNT_W      = 14
) (
    input  logic            pclk,
    input  logic            nreset,
    neopixel_chain_if.slave bus,
    output logic            np_out,
    output logic            busy
);
    localparam int               PIX_W     = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [7:0]       LAST_PIX  = 8'(NUM_PIXELS - 1);
    localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(T_BIT - 1);
    localparam logic [CNT_W-1:0] LATCH_END = CNT_W'(T_LATCH - 1);
    localparam logic [CNT_W-1:0] T0H_C     = CNT_W'(T0H);
    localparam logic [CNT_W-1:0] T1H_C     = CNT_W'(T1H);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [23:0]      shift_q, shift_d;
    logic [4:0]       bit_q, bit_d;
    logic [7:0]       pix_q, pix_d;
    logic [7:0]       idx_q, idx_d;
    logic             np_out_q, np_out_d;
    logic             busy_q, busy_d;
    logic [23:0]      mem_q [NUM_PIXELS];
    logic             auto_en;

    logic             wr_en, rd_en;
    logic             wr_ctrl, wr_idx, wr_pix;
    logic             is_busy, start, clr;
    logic [7:0]       pix_nxt;

    assign wr_en   = bus.bus_write_en & bus.np_en;
    assign rd_en   = bus.bus_read_en & bus.np_en;
    assign wr_ctrl = wr_en && (bus.bus_addr == 8'h00);
    assign wr_idx  = wr_en && (bus.bus_addr == 8'h04);
    assign wr_pix  = wr_en && (bus.bus_addr == 8'h08);
    assign is_busy = (state_q != IDLE);
    // clear wins over start when both bits are set in one CTRL write
    assign clr     = wr_ctrl & bus.bus_write_data[1] & ~is_busy;
    assign start   = wr_ctrl & bus.bus_write_data[0] & ~bus.bus_write_data[1] & ~is_busy;
    assign pix_nxt = pix_q + 8'd1;

`ifdef NP_AUTO_REFRESH_EN
    logic auto_q;

    // Auto-refresh flag: writable at any time, only sampled at the end of a latch
    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            auto_q <= 1'b0;
        end else if (wr_ctrl) begin
            auto_q <= bus.bus_write_data[2];
        end
    end

    assign auto_en = auto_q;
`else
    assign auto_en = 1'b0;
`endif

    // Index pointer: direct load with out-of-range folding to 0, or wrap-increment after a pixel write
    always_comb begin
        idx_d = idx_q;
        if (wr_idx) begin
            idx_d = (bus.bus_write_data >= 32'(NUM_PIXELS)) ? 8'd0 : bus.bus_write_data[7:0];
        end else if (wr_pix) begin
            idx_d = (idx_q == LAST_PIX) ? 8'd0 : idx_q + 8'd1;
        end
    end

    // Frame buffer and index; pixel writes are accepted even mid-frame
    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            idx_q <= '0;
            for (int i = 0; i < NUM_PIXELS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            idx_q <= idx_d;
            if (clr) begin
                for (int i = 0; i < NUM_PIXELS; i++) begin
                    mem_q[i] <= '0;
                end
            end else if (wr_pix) begin
                mem_q[idx_q[PIX_W-1:0]] <= bus.bus_write_data[23:0];
            end
        end
    end

    // Serialiser next state: bit timing, pixel load at the end of each 24-bit word, latch interval
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        pix_d    = pix_q;
        np_out_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                    pix_d   = 8'd0;
                    shift_d = mem_q[0];
                    bit_d   = 5'd0;
                    cnt_d   = '0;
                end
            end
            SEND: begin
                np_out_d = (cnt_q < (shift_q[23] ? T1H_C : T0H_C));
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    shift_d = shift_q << 1;
                    bit_d   = bit_q + 5'd1;
                    if (bit_q == 5'd23) begin
                        bit_d = 5'd0;
                        if (pix_q == LAST_PIX) begin
                            state_d = LATCH;
                        end else begin
                            pix_d   = pix_nxt;
                            shift_d = mem_q[pix_nxt[PIX_W-1:0]];
                        end
                    end
                end
            end
            LATCH: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LATCH_END) begin
                    cnt_d = '0;
                    if (auto_en) begin
                        state_d = SEND;
                        pix_d   = 8'd0;
                        shift_d = mem_q[0];
                        bit_d   = 5'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Serialiser registers; reset drops np_out immediately and abandons any frame
    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            bit_q    <= '0;
            pix_q    <= '0;
            np_out_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            pix_q    <= pix_d;
            np_out_q <= np_out_d;
            busy_q   <= busy_d;
        end
    end

    // Combinational read mux; zero whenever no read is addressed to this block
    always_comb begin
        bus.bus_read_data = '0;
        if (rd_en) begin
            case (bus.bus_addr)
                8'h00:   bus.bus_read_data = {16'b0, idx_q, 5'b0, auto_en, 1'b0, busy_q};
                8'h04:   bus.bus_read_data = {24'b0, idx_q};
                8'h08:   bus.bus_read_data = {8'b0, mem_q[idx_q[PIX_W-1:0]]};
                default: bus.bus_read_data = '0;
            endcase
        end
    end

    assign np_out = np_out_q;
    assign busy   = busy_q;

endmodule

// File: doc/neopixel_chain.md
# neopixel_chain

Parametrised WS2812-style pixel-chain driver on the processor's memory-mapped I/O bus. It holds a frame buffer of NUM_PIXELS 24-bit GRB words, written over the bus with an auto-incrementing index. On command it serialises the whole frame onto a single-wire output with per-bit high/low timing, then holds the reset/latch interval. It extends the single-pixel driver to N pixels, adds tunable timing, status readback and an optional auto-refresh mode.

## Interface
- NUM_PIXELS, 8: pixels in chain (1..256).
- T0H, 40: high cycles for a 0 bit (0.4 us at 10 ns pclk).
- T1H, 80: high cycles for a 1 bit.
- T_BIT, 125: total cycles per bit; requires T1H < T_BIT and T0H < T_BIT.
- T_LATCH, 5000: low cycles after the last bit.
- CNT_W, 14: timing counter width; must hold max(T_BIT, T_LATCH).
- pclk, in, 1: clock. One clock domain only.
- nreset, in, 1: asynchronous, active-low reset.
- bus_write_en, in, 1: bus write strobe.
- bus_read_en, in, 1: bus read strobe.
- np_en, in, 1: block select. A write is `bus_write_en & np_en`; a read is `bus_read_en & np_en`.
- bus_addr, in, 8: register offset.
- bus_write_data, in, 32: write data.
- bus_read_data, out, 32: combinational read data; 0 when no read is active.
- np_out, out, 1: registered serial pixel data.
- busy, out, 1: registered; high while a frame or latch is in progress.

## Operation
Registers:
- 0x00 CTRL (write):
  - bit0 start: ignored when busy.
  - bit1 clear: zeroes all pixels; ignored when busy.
  - bit2 auto-refresh enable: writable at any time.
  - If both start and clear are set, clear takes effect and start is ignored.
- 0x00 STATUS (read): {16'b0, idx[7:0], 5'b0, auto, 1'b0, busy}.
- 0x04 INDEX (write/read): sets idx. A value ≥ NUM_PIXELS sets idx to 0.
- 0x08 PIXEL (write): mem[idx] = data[23:0], then idx = (idx == NUM_PIXELS-1) ? 0 : idx+1. Accepted while busy.
- 0x08 PIXEL (read): {8'b0, mem[idx]}.
- Any other address: write ignored, read returns 0.

FSM (IDLE, SEND, LATCH):
- IDLE: np_out=0, busy=0. A start moves to SEND with pix=0, shift=mem[0], bit=0, cnt=0.
- SEND:
  - np_out_n = (cnt < (shift[23] ? T1H : T0H)); cnt increments.
  - At cnt == T_BIT-1: cnt=0, shift<<=1, bit++.
  - On bit 23 of a pixel: if pix == NUM_PIXELS-1, go to LATCH; otherwise pix++ and shift=mem[pix+1].
- LATCH: np_out=0. When cnt == T_LATCH-1: go to IDLE, or restart SEND at pix 0 if auto=1.
- Transmission is MSB (bit 23) first, pixel 0 first.
- The pixel word is captured at load time. Writes to an already-loaded or already-sent pixel affect only the next frame.

Reset (async, nreset=0): np_out=0, busy=0, state=IDLE, idx=0, auto=0, all counters 0, all mem words 0.

## Timing
- Start write sampled at edge N: state=SEND and busy=1 after edge N; np_out rises after edge N+1 (one-cycle register lag).
- Each bit occupies exactly T_BIT cycles on np_out, with no gaps between bits or between pixels.
- Frame length is NUM_PIXELS*24*T_BIT + T_LATCH cycles, start to busy falling.
- Auto-refresh: the next frame's first high begins T_LATCH cycles after the previous frame's last bit ends. busy stays high throughout.
- Clearing auto during a frame lets the current frame finish, then returns to IDLE.
- nreset asserted mid-frame: np_out drops to 0 immediately (asynchronous), and the frame is abandoned.

## Configuration
- NP_AUTO_REFRESH_EN defined: CTRL bit2 and the LATCH→SEND loop exist.
- NP_AUTO_REFRESH_EN undefined: bit2 writes are ignored, STATUS bit2 reads 0, and LATCH always returns to IDLE.

## Test plan
NUM_PIXELS=2, default timing unless stated.
- Reset, then read 0x00 and 0x08 → both 0; np_out=0, busy=0.
- Write INDEX=0, PIXEL=0x800001, PIXEL=0x000000; write CTRL=1.
  - Bits 23 and 0 of pixel 0 high for 80 cycles, every other bit high for 40, each bit 125 cycles.
  - busy falls 6000+5000 cycles after start.
- During that frame: CTRL=1 and CTRL=2 are ignored, mem unchanged. A PIXEL write to idx 1 after pixel 1 has loaded does not alter the current frame but appears in the next.
- INDEX write of 5 → STATUS idx=0. Three PIXEL writes from idx 0 → idx wraps 0→1→0→1.
- Auto-refresh (macro defined):
  - CTRL=5 → a second frame starts exactly T_LATCH after the first frame's last bit.
  - CTRL=0 mid-frame → busy falls after that frame's latch.
  - Macro undefined → no second frame.
- Pull nreset low at cycle 300 of a frame → np_out=0 and busy=0 at once; STATUS reads 0 after release.
